lsu_rv32: RTL and testbench

- Load/store unit directly downstream of the execute-stage ALU.
- Consumes the ALU result as the effective address for RV32I LB/LH/LW/LBU/LHU/SB/SH/SW.
- Runs one transaction at a time on a simple req/ack data-memory port. Handles byte-lane steering, store-data replication, load extraction and sign/zero extension.
- Reports completion with a one-cycle done pulse and flags errors (bus error, timeout, illegal funct3).

---
 rtl/lsu_rv32.sv | 182 ++++++++++++++++++
 tb/tb_lsu_rv32.sv | 241 ++++++++++++++++++++++++
 2 files changed

// File: rtl/lsu_rv32.sv
// RV32I load/store unit: one req/ack bus transaction at a time.
// Define LSU_MISALIGN_TRAP_EN to trap misaligned half/word accesses.
module lsu_rv32 #(
   parameter int unsigned TIMEOUT_CYCLES = 255,
   parameter int unsigned CNT_W          = 8
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        start,
   input  logic        is_store,
   input  logic [2:0]  funct3,
   input  logic [31:0] addr,
   input  logic [31:0] wdata,
   output logic        busy,
   output logic        done,
   output logic [31:0] rdata_out,
   output logic        err,
   output logic        misalign,
   output logic        mem_req,
   output logic        mem_we,
   output logic [31:0] mem_addr,
   output logic [3:0]  mem_be,
   output logic [31:0] mem_wdata,
   input  logic        mem_ack,
   input  logic        mem_err,
   input  logic [31:0] mem_rdata
);

   typedef enum logic [1:0] {IDLE, BUS, RESP} state_e;

   localparam bit TO_EN = (TIMEOUT_CYCLES != 0);
   localparam logic [CNT_W-1:0] TO_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

   state_e            state_q, state_d;
   logic              st_q, st_d;
   logic [2:0]        f3_q, f3_d;
   logic [31:0]       addr_q, addr_d;
   logic [31:0]       wdata_q, wdata_d;
   logic [31:0]       rdata_q, rdata_d;
   logic              err_q, err_d;
   logic              mis_q, mis_d;
   logic [CNT_W-1:0]  cnt_q, cnt_d;

   logic              illegal;
   logic              misal;
   logic [1:0]        o;
   logic [7:0]        lb;
   logic [15:0]       lh;
   logic [31:0]       ld_val;
   logic [3:0]        be;
   logic [31:0]       st_val;
   logic              in_bus;

   assign illegal = is_store ? (funct3[2] | (funct3[1:0] == 2'b11))
                             : ((funct3 == 3'b011) | (funct3[2:1] == 2'b11));

`ifdef LSU_MISALIGN_TRAP_EN
   assign misal = ((funct3[1:0] == 2'b01) & addr[0]) |
                  ((funct3[1:0] == 2'b10) & (addr[1:0] != 2'b00));
`else
   assign misal = 1'b0;
`endif

   assign o  = addr_q[1:0];
   assign lb = mem_rdata[{o, 3'b000} +: 8];
   assign lh = mem_rdata[{o[1], 4'b0000} +: 16];

   always_comb begin
      ld_val = mem_rdata;
      case (f3_q)
         3'b000:  ld_val = {{24{lb[7]}}, lb};
         3'b001:  ld_val = {{16{lh[15]}}, lh};
         3'b100:  ld_val = {24'd0, lb};
         3'b101:  ld_val = {16'd0, lh};
         default: ld_val = mem_rdata;
      endcase
   end

   // Sub-word stores replicate data across lanes; be selects the live lane.
   always_comb begin
      be     = 4'b1111;
      st_val = wdata_q;
      case (f3_q[1:0])
         2'b00: begin
            be     = 4'b0001 << o;
            st_val = {4{wdata_q[7:0]}};
         end
         2'b01: begin
            be     = 4'b0011 << {o[1], 1'b0};
            st_val = {2{wdata_q[15:0]}};
         end
         default: begin
            be     = 4'b1111;
            st_val = wdata_q;
         end
      endcase
   end

   always_comb begin
      state_d = state_q;
      st_d    = st_q;
      f3_d    = f3_q;
      addr_d  = addr_q;
      wdata_d = wdata_q;
      rdata_d = rdata_q;
      err_d   = err_q;
      mis_d   = mis_q;
      cnt_d   = cnt_q;
      case (state_q)
         IDLE: begin
            if (start) begin
               st_d    = is_store;
               f3_d    = funct3;
               addr_d  = addr;
               wdata_d = wdata;
               err_d   = 1'b0;
               mis_d   = 1'b0;
               cnt_d   = '0;
               if (illegal || misal) begin
                  state_d = RESP;
                  err_d   = 1'b1;
                  mis_d   = misal & ~illegal;
               end else begin
                  state_d = BUS;
               end
            end
         end
         BUS: begin
            cnt_d = cnt_q + CNT_W'(1);
            if (mem_err) begin
               state_d = RESP;
               err_d   = 1'b1;
            end else if (mem_ack) begin
               state_d = RESP;
               if (!st_q) rdata_d = ld_val;
            end else if (TO_EN && (cnt_q == TO_LAST)) begin
               state_d = RESP;
               err_d   = 1'b1;
            end
         end
         RESP: state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= IDLE;
         st_q    <= 1'b0;
         f3_q    <= 3'b000;
         addr_q  <= '0;
         wdata_q <= '0;
         rdata_q <= '0;
         err_q   <= 1'b0;
         mis_q   <= 1'b0;
         cnt_q   <= '0;
      end else begin
         state_q <= state_d;
         st_q    <= st_d;
         f3_q    <= f3_d;
         addr_q  <= addr_d;
         wdata_q <= wdata_d;
         rdata_q <= rdata_d;
         err_q   <= err_d;
         mis_q   <= mis_d;
         cnt_q   <= cnt_d;
      end
   end

   assign in_bus    = (state_q == BUS);
   assign busy      = (state_q != IDLE);
   assign done      = (state_q == RESP);
   assign rdata_out = rdata_q;
   assign err       = err_q;
   assign misalign  = mis_q;
   assign mem_req   = in_bus;
   assign mem_we    = in_bus & st_q;
   assign mem_addr  = in_bus ? {addr_q[31:2], 2'b00} : 32'd0;
   assign mem_be    = (in_bus & st_q) ? be : 4'b0000;
   assign mem_wdata = (in_bus & st_q) ? st_val : 32'd0;

endmodule

// File: tb/tb_lsu_rv32.sv
// Directed bench for lsu_rv32: vector table plus multi-cycle sequences.
module tb_lsu_rv32;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        start, start2;
   logic        is_store;
   logic [2:0]  funct3;
   logic [31:0] addr, wdata;
   logic        busy, done, err, misalign;
   logic [31:0] rdata_out;
   logic        mem_req, mem_we;
   logic [31:0] mem_addr, mem_wdata;
   logic [3:0]  mem_be;
   logic        mem_ack, mem_err;
   logic [31:0] mem_rdata;
   logic        busy2, done2, err2, mis2;
   logic [31:0] rdata2;
   logic        req2, we2;
   logic [31:0] maddr2, wd2;
   logic [3:0]  be2;
   logic        ack2, merr2;

   int tests = 0;
   int fails = 0;

   always #5 clk = ~clk;

   lsu_rv32 dut (
      .clk(clk), .rst_n(rst_n), .start(start), .is_store(is_store),
      .funct3(funct3), .addr(addr), .wdata(wdata), .busy(busy),
      .done(done), .rdata_out(rdata_out), .err(err),
      .misalign(misalign), .mem_req(mem_req), .mem_we(mem_we),
      .mem_addr(mem_addr), .mem_be(mem_be), .mem_wdata(mem_wdata),
      .mem_ack(mem_ack), .mem_err(mem_err), .mem_rdata(mem_rdata)
   );

   lsu_rv32 #(.TIMEOUT_CYCLES(4), .CNT_W(8)) dut_to (
      .clk(clk), .rst_n(rst_n), .start(start2), .is_store(is_store),
      .funct3(funct3), .addr(addr), .wdata(wdata), .busy(busy2),
      .done(done2), .rdata_out(rdata2), .err(err2),
      .misalign(mis2), .mem_req(req2), .mem_we(we2),
      .mem_addr(maddr2), .mem_be(be2), .mem_wdata(wd2),
      .mem_ack(ack2), .mem_err(merr2), .mem_rdata(mem_rdata)
   );

   task automatic chk(input string nm, input logic [31:0] act,
                      input logic [31:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %h want %h", nm, act, exp);
      end
   endtask

   typedef struct {
      logic        st;
      logic [2:0]  f3;
      logic [31:0] a;
      logic [31:0] wd;
      logic [31:0] rd;
      logic        bus;
      logic [3:0]  be;
      logic [31:0] mwd;
      logic [31:0] exp_rd;
      logic        e;
      logic        m;
   } vec_t;

   localparam int NV = 13;
   vec_t v [NV];

   initial begin
      int reqs;
      int dones;

      v[0]  = '{1'b1, 3'b000, 32'h0000_1003, 32'h0000_00A5, 32'h0,
                1'b1, 4'b1000, 32'hA5A5_A5A5, 32'h0, 1'b0, 1'b0};
      v[1]  = '{1'b0, 3'b000, 32'h0000_2001, 32'h0, 32'h1234_80FF,
                1'b1, 4'b0000, 32'h0, 32'hFFFF_FF80, 1'b0, 1'b0};
      v[2]  = '{1'b0, 3'b100, 32'h0000_2001, 32'h0, 32'h1234_80FF,
                1'b1, 4'b0000, 32'h0, 32'h0000_0080, 1'b0, 1'b0};
      v[3]  = '{1'b0, 3'b101, 32'h0000_2002, 32'h0, 32'h1234_80FF,
                1'b1, 4'b0000, 32'h0, 32'h0000_1234, 1'b0, 1'b0};
      v[4]  = '{1'b0, 3'b001, 32'h0000_2000, 32'h0, 32'h0000_8001,
                1'b1, 4'b0000, 32'h0, 32'hFFFF_8001, 1'b0, 1'b0};
      v[5]  = '{1'b0, 3'b010, 32'h0000_2004, 32'h0, 32'hDEAD_BEEF,
                1'b1, 4'b0000, 32'h0, 32'hDEAD_BEEF, 1'b0, 1'b0};
      v[6]  = '{1'b1, 3'b001, 32'h0000_2002, 32'h1234_ABCD, 32'h0,
                1'b1, 4'b1100, 32'hABCD_ABCD, 32'hDEAD_BEEF, 1'b0, 1'b0};
      v[7]  = '{1'b1, 3'b010, 32'h0000_2008, 32'hCAFE_F00D, 32'h0,
                1'b1, 4'b1111, 32'hCAFE_F00D, 32'hDEAD_BEEF, 1'b0, 1'b0};
      v[8]  = '{1'b0, 3'b011, 32'h0000_2000, 32'h0, 32'h5555_5555,
                1'b0, 4'b0000, 32'h0, 32'hDEAD_BEEF, 1'b1, 1'b0};
      v[9]  = '{1'b1, 3'b100, 32'h0000_2000, 32'h1, 32'h0,
                1'b0, 4'b0000, 32'h0, 32'hDEAD_BEEF, 1'b1, 1'b0};
`ifdef LSU_MISALIGN_TRAP_EN
      v[10] = '{1'b0, 3'b001, 32'h0000_4001, 32'h0, 32'hAAAA_7FFE,
                1'b0, 4'b0000, 32'h0, 32'hDEAD_BEEF, 1'b1, 1'b1};
`else
      v[10] = '{1'b0, 3'b001, 32'h0000_4001, 32'h0, 32'hAAAA_7FFE,
                1'b1, 4'b0000, 32'h0, 32'h0000_7FFE, 1'b0, 1'b0};
`endif
      v[11] = '{1'b0, 3'b100, 32'h0000_4003, 32'h0, 32'hAAAA_7FFE,
                1'b1, 4'b0000, 32'h0, 32'h0000_00AA, 1'b0, 1'b0};
      v[12] = '{1'b0, 3'b001, 32'h0000_4002, 32'h0, 32'hAAAA_7FFE,
                1'b1, 4'b0000, 32'h0, 32'hFFFF_AAAA, 1'b0, 1'b0};

      rst_n = 1'b0; start = 1'b0; start2 = 1'b0; is_store = 1'b0;
      funct3 = 3'b000; addr = '0; wdata = '0; mem_ack = 1'b0;
      mem_err = 1'b0; mem_rdata = '0; ack2 = 1'b0; merr2 = 1'b0;
      repeat (2) @(negedge clk);
      chk("rst_busy", {31'd0, busy}, 32'd0);
      chk("rst_done", {31'd0, done}, 32'd0);
      chk("rst_req", {31'd0, mem_req}, 32'd0);
      chk("rst_rdata", rdata_out, 32'd0);
      chk("rst_err", {30'd0, err, misalign}, 32'd0);
      chk("rst_bus", mem_addr | mem_wdata | {28'd0, mem_be}, 32'd0);
      rst_n = 1'b1;

      // Table-driven single transactions, ack on the first bus cycle
      for (int i = 0; i < NV; i++) begin
         @(negedge clk);
         start = 1'b1; is_store = v[i].st; funct3 = v[i].f3;
         addr = v[i].a; wdata = v[i].wd; mem_rdata = v[i].rd;
         @(negedge clk);
         start = 1'b0;
         if (v[i].bus) begin
            chk($sformatf("v%0d_req", i), {31'd0, mem_req}, 32'd1);
            chk($sformatf("v%0d_we", i), {31'd0, mem_we}, {31'd0, v[i].st});
            chk($sformatf("v%0d_addr", i), mem_addr, {v[i].a[31:2], 2'b00});
            chk($sformatf("v%0d_be", i), {28'd0, mem_be}, {28'd0, v[i].be});
            chk($sformatf("v%0d_wd", i), mem_wdata, v[i].mwd);
            chk($sformatf("v%0d_mdone", i), {31'd0, done}, 32'd0);
            mem_ack = 1'b1;
            @(negedge clk);
            mem_ack = 1'b0;
         end else begin
            chk($sformatf("v%0d_noreq", i), {31'd0, mem_req}, 32'd0);
         end
         chk($sformatf("v%0d_done", i), {31'd0, done}, 32'd1);
         chk($sformatf("v%0d_busy", i), {31'd0, busy}, 32'd1);
         chk($sformatf("v%0d_err", i), {31'd0, err}, {31'd0, v[i].e});
         chk($sformatf("v%0d_mis", i), {31'd0, misalign}, {31'd0, v[i].m});
         chk($sformatf("v%0d_rd", i), rdata_out, v[i].exp_rd);
         @(negedge clk);
         chk($sformatf("v%0d_idle", i), {30'd0, done, busy}, 32'd0);
         chk($sformatf("v%0d_errhold", i), {31'd0, err}, {31'd0, v[i].e});
      end

      // LW with ack after 6 bus cycles; a second start mid-BUS is ignored
      @(negedge clk);
      start = 1'b1; is_store = 1'b0; funct3 = 3'b010;
      addr = 32'h0000_3000; mem_rdata = 32'h1122_3344;
      reqs = 0;
      for (int i = 1; i <= 6; i++) begin
         @(negedge clk);
         start = (i == 3);
         if (i == 3) addr = 32'h0000_5555;
         if (mem_req && mem_addr == 32'h0000_3000 && mem_be == 4'b0000 &&
             !mem_we && !done)
            reqs++;
         if (i == 6) mem_ack = 1'b1;
      end
      chk("dly_reqcycles", reqs, 6);
      @(negedge clk);
      mem_ack = 1'b0; start = 1'b0;
      chk("dly_done", {31'd0, done}, 32'd1);
      chk("dly_rd", rdata_out, 32'h1122_3344);
      dones = 0;
      for (int i = 0; i < 6; i++) begin
         @(negedge clk);
         if (done || mem_req) dones++;
      end
      chk("dly_no2nd", dones, 0);

      // ack and err together: err wins, rdata held
      @(negedge clk);
      start = 1'b1; funct3 = 3'b010; addr = 32'h0000_3000;
      mem_rdata = 32'h9999_9999;
      @(negedge clk);
      start = 1'b0; mem_ack = 1'b1; mem_err = 1'b1;
      @(negedge clk);
      mem_ack = 1'b0; mem_err = 1'b0;
      chk("ackerr_done", {31'd0, done}, 32'd1);
      chk("ackerr_err", {31'd0, err}, 32'd1);
      chk("ackerr_rd", rdata_out, 32'h1122_3344);

      // Timeout instance: one good load, then a load that never acks
      @(negedge clk);
      start2 = 1'b1; funct3 = 3'b010; addr = 32'h0000_3000;
      mem_rdata = 32'h0BAD_F00D;
      @(negedge clk);
      start2 = 1'b0; ack2 = 1'b1;
      @(negedge clk);
      ack2 = 1'b0;
      chk("to_first_rd", rdata2, 32'h0BAD_F00D);
      @(negedge clk);
      start2 = 1'b1; mem_rdata = 32'h7777_7777;
      reqs = 0;
      dones = 0;
      for (int i = 0; i < 20; i++) begin
         @(negedge clk);
         start2 = 1'b0;
         if (req2) reqs++;
         if (done2) begin
            dones = 1;
            break;
         end
      end
      chk("to_seen_done", dones, 1);
      chk("to_reqcycles", reqs, 4);
      chk("to_err", {31'd0, err2}, 32'd1);
      chk("to_rd_hold", rdata2, 32'h0BAD_F00D);
      chk("to_req_low", {31'd0, req2}, 32'd0);

      // Reset asserted in the middle of a bus transaction
      @(negedge clk);
      start = 1'b1; funct3 = 3'b010; addr = 32'h0000_3000;
      @(negedge clk);
      start = 1'b0;
      chk("rstmid_req", {31'd0, mem_req}, 32'd1);
      #2 rst_n = 1'b0;
      #1;
      chk("rstmid_req0", {31'd0, mem_req}, 32'd0);
      chk("rstmid_busy0", {30'd0, busy, done}, 32'd0);
      chk("rstmid_outs", rdata_out | mem_addr | {31'd0, err}, 32'd0);
      @(negedge clk);
      rst_n = 1'b1;
      dones = 0;
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         if (done || mem_req) dones++;
      end
      chk("rstmid_nodone", dones, 0);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
